// File: rtl/fft_top_pkg.sv
// Shared defaults and constants for the FFT product rounding path.
package fft_top_pkg;
    localparam int DIN_WIDTH_DEF   = 35;
    localparam int DOUT_WIDTH_DEF  = 16;
    localparam int SHIFT_WIDTH_DEF = 5;
    localparam int MAX_SHIFT_DEF   = DIN_WIDTH_DEF - DOUT_WIDTH_DEF;
    localparam int SAT_CNT_WIDTH   = 16;
endpackage

// File: rtl/fft_top_round_even.sv
// Combinational arithmetic right shift with round-half-to-even.
// The output carries one guard bit above DIN_WIDTH.
module fft_top_round_even
    import fft_top_pkg::*;
#(
    parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic signed [DIN_WIDTH-1:0]   value,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [DIN_WIDTH:0]     rounded
);
    localparam int W = DIN_WIDTH + 1;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] floor_q;
    logic        [W-1:0] mask;
    logic        [W-1:0] rem;
    logic        [W-1:0] half;

    always_comb begin
        ext     = {value[DIN_WIDTH-1], value};
        floor_q = ext >>> shift;
        mask    = ~({W{1'b1}} << shift);
        rem     = ext & mask;
        half    = (W'(1) << shift) >> 1;
        rounded = floor_q;
        // Exact halves go to the even neighbour; shift 0 has no fraction at all.
        if (shift != '0) begin
            if ((rem > half) || ((rem == half) && floor_q[0])) begin
                rounded = floor_q + W'(1);
            end
        end
    end
endmodule

// File: rtl/fft_top_prod_round.sv
// Two-stage product rounding: S1 shifts and rounds, S2 saturates and
// tracks overflow. Shift amount is latched once per frame.
module fft_top_prod_round
    import fft_top_pkg::*;
#(
    parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH  = DOUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [DIN_WIDTH-1:0]    in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    input  logic        [SHIFT_WIDTH-1:0]  shift_cfg,
    input  logic                           clear_ovf,
    output logic signed [DOUT_WIDTH-1:0]   out_data,
    output logic                           out_valid,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           ovf,
    output logic        [SAT_CNT_WIDTH-1:0] sat_count
);
    localparam int RW = DIN_WIDTH + 1;
    localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT = SHIFT_WIDTH'(DIN_WIDTH - DOUT_WIDTH);
    localparam logic signed [RW-1:0]   SAT_MAX   = RW'(2 ** (DOUT_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0]   SAT_MIN   = RW'(-(2 ** (DOUT_WIDTH - 1)));
    localparam logic [SAT_CNT_WIDTH-1:0] CNT_MAX = {SAT_CNT_WIDTH{1'b1}};

    logic                    frame_start;
    logic [SHIFT_WIDTH-1:0]  shift_lat;
    logic [SHIFT_WIDTH-1:0]  cfg_clamped;
    logic [SHIFT_WIDTH-1:0]  shift_eff;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    s1_data;
    logic                    s1_valid;
    logic                    s1_last;
    logic                    s2_adv;
    logic                    s1_load;
    logic                    s2_load;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    sat_event;
    logic signed [DOUT_WIDTH-1:0] sat_val;

    // Handshake: a beat moves on valid&ready at a rising edge; ready never
    // looks at valid, and a stage loads whenever it is empty or drains.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_adv;

    assign cfg_clamped = (shift_cfg > MAX_SHIFT) ? MAX_SHIFT : shift_cfg;
    assign shift_eff   = frame_start ? cfg_clamped : shift_lat;

    fft_top_round_even #(
        .DIN_WIDTH  (DIN_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_round (
        .value  (in_data),
        .shift  (shift_eff),
        .rounded(rnd)
    );

    assign sat_hi    = s1_data > SAT_MAX;
    assign sat_lo    = s1_data < SAT_MIN;
    assign sat_val   = sat_hi ? SAT_MAX[DOUT_WIDTH-1:0] :
                       sat_lo ? SAT_MIN[DOUT_WIDTH-1:0] : s1_data[DOUT_WIDTH-1:0];
    assign sat_event = s2_load && (sat_hi || sat_lo);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b1;
            shift_lat   <= '0;
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_last     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            ovf         <= 1'b0;
            sat_count   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid    <= 1'b1;
                s1_data     <= rnd;
                s1_last     <= in_last;
                frame_start <= in_last;
                if (frame_start) shift_lat <= cfg_clamped;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= sat_val;
                out_last  <= s1_last;
            end else if (s2_adv) begin
                out_valid <= 1'b0;
            end

            // A saturation on the same edge as a clear wins, restarting the count at 1.
            if (sat_event) begin
                ovf <= 1'b1;
                if (clear_ovf)              sat_count <= SAT_CNT_WIDTH'(1);
                else if (sat_count != CNT_MAX) sat_count <= sat_count + SAT_CNT_WIDTH'(1);
            end else if (clear_ovf) begin
                ovf       <= 1'b0;
                sat_count <= '0;
            end
        end
    end
endmodule
